// File: rtl/sram_ctrl_pkg.sv
// Shared types, default timing and parameter checks for the asynchronous-SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefAddrW    = 18;
  localparam int unsigned DefSetupCyc = 1;
  localparam int unsigned DefPulseCyc = 2;
  localparam int unsigned DefHoldCyc  = 1;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic bit params_ok(int unsigned data_w, int unsigned setup_cyc,
                                   int unsigned pulse_cyc, int unsigned hold_cyc);
    return (data_w > 0) && (data_w % 8 == 0) &&
           (setup_cyc >= 1) && (pulse_cyc >= 1) && (hold_cyc >= 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_seq_io.sv
// Tristate data buffer: registered drive enable and output data, unregistered input path.
module sram_io_buf #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              drv_i,
  output logic [DATA_W-1:0] rdata_o,
  inout  wire  [DATA_W-1:0] ram_data_io
);

  logic              drv_q;
  logic [DATA_W-1:0] dout_q, dout_d;

  assign dout_d = load_i ? wdata_i : dout_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drv_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      drv_q  <= drv_i;
      dout_q <= dout_d;
    end
  end

  assign ram_data_io = drv_q ? dout_q : {DATA_W{1'bz}};
  assign rdata_o     = ram_data_io;

endmodule

// File: rtl/sram_ctrl_seq.sv
// Asynchronous-SRAM controller: one read/write per handshake, CE/OE/WE sequenced through
// SETUP, PULSE and HOLD wait states with every pin driven from a register.
module sram_ctrl_seq
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned SETUP_CYC = DefSetupCyc,
  parameter int unsigned PULSE_CYC = DefPulseCyc,
  parameter int unsigned HOLD_CYC  = DefHoldCyc
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                ready,
  output logic                done,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n,
  output logic [DATA_W/8-1:0] ram_be_n,
  inout  wire  [DATA_W-1:0]   ram_data
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

  if (!params_ok(DATA_W, SETUP_CYC, PULSE_CYC, HOLD_CYC)) begin : gen_param_err
    $error("sram_ctrl_seq: DATA_W must be a multiple of 8 and all wait counts >= 1");
  end

  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t SetupLd = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t PulseLd = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t HoldLd  = cnt_t'(HOLD_CYC - 1);

  state_e             state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BeW-1:0]     be_q, be_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d, bus_in;
  logic               accept, capture, busy_d, drv_d;
  logic               done_q, done_d, rvalid_q, rvalid_d, ready_q;
  logic               ce_n_q, oe_n_q, we_n_q;
  logic [BeW-1:0]     be_n_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          we_d    = req_we;
          addr_d  = req_addr;
          be_d    = req_be;
          state_d = StSetup;
          cnt_d   = SetupLd;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          capture = !we_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d  = StIdle;
          cnt_d    = '0;
          done_d   = 1'b1;
          rvalid_d = !we_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
    rdata_d = capture ? bus_in : rdata_q;
  end

  // Pin values are derived from the next state so each strobe lands in its own register.
  assign busy_d = (state_d != StIdle);
  assign drv_d  = busy_d && we_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      ready_q  <= !busy_d;
      ce_n_q   <= !busy_d;
      oe_n_q   <= !(busy_d && !we_d && (state_d != StHold));
      we_n_q   <= !(we_d && (state_d == StPulse));
      be_n_q   <= busy_d ? ~be_d : '1;
    end
  end

  sram_io_buf #(
    .DATA_W(DATA_W)
  ) u_io_buf (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (accept),
    .wdata_i    (req_wdata),
    .drv_i      (drv_d),
    .rdata_o    (bus_in),
    .ram_data_io(ram_data)
  );

  assign ready    = ready_q;
  assign done     = done_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_ce_n = ce_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;
  assign ram_be_n = be_n_q;

endmodule

// File: doc/sram_ctrl_seq.md
# sram_ctrl_seq

Clocked, parametrised asynchronous-SRAM controller that replaces the level-triggered RAM controller. It sits between the UART/command logic and the external SRAM pins. It accepts one read or write per valid/ready handshake and sequences CE/OE/WE with programmable setup, pulse and hold wait states. It owns the bidirectional data bus, including the read-to-write turnaround, and reports completion with a one-cycle `done` pulse and, for reads, `rvalid` plus registered `rdata`.

## Interface
Parameters:
- `DATA_W`, 16: data bus width; must be a multiple of 8.
- `ADDR_W`, 18: word address width.
- `SETUP_CYC`, 1: cycles with address, CE and data (write) or OE (read) stable before the strobe. Must be ≥1.
- `PULSE_CYC`, 2: cycles of WE low (write) or read-access wait. Must be ≥1.
- `HOLD_CYC`, 1: cycles after the strobe, covering write data hold or read turnaround. Must be ≥1.

Ports:
- `clk`  in  1  single clock; the block has one clock only.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  1  request valid.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `req_be`  in  DATA_W/8  byte enables, active high.
- `ready`  out  1  controller can accept a request (IDLE).
- `done`  out  1  one-cycle pulse: operation finished.
- `rvalid`  out  1  one-cycle pulse with `done` on reads.
- `rdata`  out  DATA_W  read data, held until the next read completes.
- `ram_addr`  out  ADDR_W  SRAM address.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n`  out  1 each  SRAM strobes, active low.
- `ram_be_n`  out  DATA_W/8  SRAM byte lanes, active low.
- `ram_data`  inout  DATA_W  SRAM data bus.

## Operation
- States are IDLE, SETUP, PULSE, HOLD. A down-counter loads N-1 on entry to each state, and the state exits when the counter reaches 0.
- Accept: on a rising edge with `req && ready`, latch `req_we`, `req_addr`, `req_wdata` and `req_be`, then go to SETUP.
- Write sequence:
  - SETUP: CE=0, OE=1, WE=1, bus driven.
  - PULSE: WE=0, bus driven.
  - HOLD: WE=1, bus still driven, CE=0.
- Read sequence:
  - SETUP and PULSE: CE=0, OE=0, WE=1, bus Z.
  - `rdata` captures `ram_data` on the final PULSE edge.
  - HOLD: OE=1, CE=0, bus Z (turnaround).
- HOLD goes to IDLE. `done` (and `rvalid` on reads) is high during the first IDLE cycle.
- IDLE outputs: CE=1, OE=1, WE=1, all `ram_be_n`=1, bus Z, `ready`=1.
- Bus drive enable is registered and high only in the write SETUP, PULSE and HOLD states. Because OE is always high for ≥1 HOLD cycle before any write, bus contention cannot occur.
- `req` while not ready is ignored. The requester holds `req` and its fields until the handshake completes.
- A new request may be accepted in the same cycle `done` is high.
- Reset (`rst_n`=0 at an edge, including mid-operation):
  - State returns to IDLE and the counter clears.
  - All strobes and `ram_be_n` go to 1, the bus goes to Z, and `done`=`rvalid`=0.
  - `rdata`=0 and `ram_addr`=0; `ready`=1 after the reset edge.
  - An aborted operation produces no `done`.

## Timing
- All outputs are registered except `ram_data` tristate (registered enable and data).
- Let S = SETUP_CYC + PULSE_CYC + HOLD_CYC. `done` rises S edges after the accepting edge. The defaults give S=4.
- Throughput is one operation per S+1 cycles. Back-to-back accept on the `done` cycle gives 1 idle cycle between operations.
- The WE low width is exactly PULSE_CYC cycles. The address is stable from the first SETUP cycle to the last HOLD cycle.
- Counter width is $clog2 of the largest of SETUP_CYC, PULSE_CYC and HOLD_CYC, plus 1. The counter never wraps.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum;
  - default timing constants;
  - the elaboration checks for `DATA_W % 8 == 0` and all timing parameters ≥1.
- Sub-module `sram_io_buf` holds the tristate data buffer: drive enable, output register, input path. Everything else lives in the top FSM.

## Test plan
- Write, defaults: addr 0x00012, data 0xBEEF, be 2'b11.
  - WE low for exactly 2 cycles; bus driven with 0xBEEF for 4 cycles.
  - `done` exactly 4 edges after accept.
- Read, defaults: SRAM model returns 0xBEEF at addr 0x00012.
  - OE low for 3 cycles; bus Z throughout.
  - `rvalid`/`done` at +4; `rdata`=0xBEEF.
- Back-to-back read then write, `req` held:
  - second accept on the `done` cycle;
  - the bus is never driven while OE=0.
- Parameter sweep SETUP/PULSE/HOLD = 3/5/2:
  - `done` at +10;
  - WE low exactly 5 cycles.
- `rst_n`=0 during write PULSE:
  - next cycle CE=OE=WE=1, bus Z, no `done`;
  - `ready`=1 after release.
- Byte write with be 2'b01 → `ram_be_n`=2'b10 during SETUP/PULSE/HOLD; 2'b11 in IDLE.
